// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader.
// Takes a byte stream holding a program image, packs it big-endian into
// 32-bit words and writes them to memory from mem_start upward. The CPU
// stays in reset until the final word has been written. If the image holds
// more than max_words words, the loader stops in ERR and keeps the CPU in
// reset, so a truncated image never runs.
module prog_loader #(
  parameter logic [31:0] mem_start = 32'h8002_0000,
  parameter int unsigned max_words = 256,
  // Word-size code for the memory's access-size port. Keep it equal to
  // sz_word in the core's parameter package.
  parameter logic [1:0]  sz_word   = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [1:0]  mem_access_sz,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [15:0] MAX_WC = 16'(max_words);

  state_t      state_reg, state_next;
  logic [1:0]  byte_idx_reg, byte_idx_next;
  logic [31:0] asm_reg, asm_next;
  logic        last_reg, last_next;
  logic [15:0] word_count_reg, word_count_next;

  logic        accept;
  logic        full;
  logic [31:0] asm_fill;

  assign accept = in_valid && in_ready;
  assign full   = (word_count_reg == MAX_WC);

  // Byte lanes: the byte at index gi lands in bits [31-8*gi -: 8], so
  // index 0 is the most significant byte. Lanes that have not been filled
  // yet still hold zero, which gives zero padding for a short last word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_fill[31-8*gi -: 8] = (byte_idx_reg == 2'(gi)) ? in_byte
                                                               : asm_reg[31-8*gi -: 8];
    end
  endgenerate

  // State register plus the assembly, index and word-count registers.
  // The reset is asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= LOAD;
      byte_idx_reg   <= 2'd0;
      asm_reg        <= 32'd0;
      last_reg       <= 1'b0;
      word_count_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      byte_idx_reg   <= byte_idx_next;
      asm_reg        <= asm_next;
      last_reg       <= last_next;
      word_count_reg <= word_count_next;
    end
  end

  // Next-state logic. Overflow is tested before assembly, so a byte that
  // arrives when the image is already full is dropped and nothing is written.
  always_comb begin
    state_next      = state_reg;
    byte_idx_next   = byte_idx_reg;
    asm_next        = asm_reg;
    last_next       = last_reg;
    word_count_next = word_count_reg;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          if (full) begin
            state_next = ERR;
          end else begin
            asm_next      = asm_fill;
            byte_idx_next = byte_idx_reg + 2'd1;
            last_next     = in_last;
            if (byte_idx_reg == 2'd3 || in_last) begin
              state_next = WRITE;
            end
          end
        end
      end
      WRITE: begin
        // The memory latches the write at the end of this cycle. Then clear
        // the assembly state for the next word.
        word_count_next = word_count_reg + 16'd1;
        byte_idx_next   = 2'd0;
        asm_next        = 32'd0;
        last_next       = 1'b0;
        state_next      = last_reg ? DONE : LOAD;
      end
      default: begin
        // DONE and ERR hold until the next reset.
      end
    endcase
  end

  // Outputs decoded from the state. The write address follows the count of
  // words written, so it equals mem_start while in reset.
  always_comb begin
    in_ready      = (state_reg == LOAD) && !reset;
    mem_enable    = (state_reg == WRITE);
    mem_rw        = (state_reg != WRITE);
    mem_access_sz = sz_word;
    mem_addr      = mem_start + {14'd0, word_count_reg, 2'b00};
    mem_din       = (state_reg == WRITE) ? asm_reg : 32'd0;
    cpu_reset     = (state_reg != DONE);
    load_done     = (state_reg == DONE);
    error         = (state_reg == ERR);
    word_count    = word_count_reg;
  end

endmodule
